// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: 2-flop sync, stability-count debounce,
// registered press/release strobes and an optional auto-repeat stage (DEBOUNCE_REPEAT_EN).
module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] button_press,
  output logic [CHANNELS-1:0] button_state,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_bank: CHANNELS must be >= 1");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("debounce_bank: STABLE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("debounce_bank: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  // Debounce next-state: the held level flips only after STABLE_CYCLES
  // consecutive evaluations with the synchronised input disagreeing.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no latch can be inferred.
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      // NOTE: the counter array is tiny per-channel state, not a RAM, so it is reset with everything else.
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the two synchroniser stages as distinct flops.
      sync1_q   <= button_press;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign button_state  = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = $clog2(RC_MAX + 1);
  localparam logic [RC_W-1:0] DELAY_V  = RC_W'(REPEAT_DELAY);
  localparam logic [RC_W-1:0] PERIOD_V = RC_W'(REPEAT_PERIOD);

  logic [CHANNELS-1:0] flip;
  logic [CHANNELS-1:0] armed_q, armed_d;
  logic [CHANNELS-1:0] repeat_q, repeat_d;
  logic [RC_W-1:0]     rc_q [CHANNELS];
  logic [RC_W-1:0]     rc_d [CHANNELS];

  assign flip = level_d ^ level_q;

  // The counter is held clear while released and on both press and release
  // edges, so a repeat strobe can never coincide with either pulse.
  always_comb begin
    armed_d  = armed_q;
    repeat_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rc_d[i] = rc_q[i];
      if (!level_q[i] || flip[i]) begin
        rc_d[i]    = '0;
        armed_d[i] = 1'b0;
      end else if ((rc_q[i] + RC_W'(1)) == (armed_q[i] ? PERIOD_V : DELAY_V)) begin
        rc_d[i]     = '0;
        armed_d[i]  = 1'b1;
        repeat_d[i] = 1'b1;
      end else begin
        rc_d[i] = rc_q[i] + RC_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed_q  <= '0;
      repeat_q <= '0;
      for (int i = 0; i < CHANNELS; i++) rc_q[i] <= '0;
    end else begin
      armed_q  <= armed_d;
      repeat_q <= repeat_d;
      for (int i = 0; i < CHANNELS; i++) rc_q[i] <= rc_d[i];
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: CHANNELS=4, STABLE_CYCLES=4, repeat delay 10 / period 5.
module tb_debounce_bank;

  logic       clock;
  logic       reset_n;
  logic [3:0] button_press;
  logic [3:0] button_state;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] repeat_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  debounce_bank #(
    .CHANNELS      (4),
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (5)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .button_press  (button_press),
    .button_state  (button_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int press_cnt;
    int release_cnt;
    int press_at;
    logic rep_exp;

    reset_n      = 1'b0;
    button_press = 4'b0000;
    #22;
    check("reset_state",   32'(button_state),  32'h0);
    check("reset_press",   32'(press_pulse),   32'h0);
    check("reset_release", 32'(release_pulse), 32'h0);
    check("reset_repeat",  32'(repeat_pulse),  32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(3);

    // Clean press on channel 0: level and pulse appear after edge 5.
    button_press[0] = 1'b1;
    tick(5);
    check("clean_before_state", 32'(button_state), 32'h0);
    check("clean_before_press", 32'(press_pulse),  32'h0);
    tick(1);
    check("clean_state",  32'(button_state), 32'h1);
    check("clean_press",  32'(press_pulse),  32'h1);
    tick(1);
    check("clean_press_gone", 32'(press_pulse),  32'h0);
    check("clean_held",       32'(button_state), 32'h1);
    button_press[0] = 1'b0;
    tick(6);
    check("clean_release",       32'(release_pulse), 32'h1);
    check("clean_release_state", 32'(button_state),  32'h0);
    tick(1);
    check("clean_release_gone", 32'(release_pulse), 32'h0);
    tick(3);

    // Bounce on channel 1: 2-cycle segments never survive; the final hold does.
    press_cnt = 0;
    release_cnt = 0;
    for (int seg = 0; seg < 10; seg++) begin
      button_press[1] = (seg % 2 == 0);
      for (int c = 0; c < 2; c++) begin
        tick(1);
        press_cnt   += int'(press_pulse[1]);
        release_cnt += int'(release_pulse[1]);
      end
    end
    check("bounce_no_state", 32'(button_state[1]), 32'h0);
    button_press[1] = 1'b1;
    press_at = 0;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      if (press_pulse[1]) press_at = c;
      press_cnt   += int'(press_pulse[1]);
      release_cnt += int'(release_pulse[1]);
    end
    check("bounce_press_count",   32'(press_cnt),       32'd1);
    check("bounce_release_count", 32'(release_cnt),     32'd0);
    check("bounce_press_cycle",   32'(press_at),        32'd6);
    check("bounce_final_state",   32'(button_state[1]), 32'h1);

    // Glitch on channel 2: a 3-cycle high is filtered out.
    press_cnt = 0;
    button_press[2] = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) button_press[2] = 1'b0;
      tick(1);
      press_cnt += int'(press_pulse[2]);
      check("glitch_state", 32'(button_state[2]), 32'h0);
    end
    check("glitch_press_count", 32'(press_cnt), 32'd0);
    button_press[2] = 1'b1;
    tick(6);
    check("glitch_then_press", 32'(press_pulse), 32'h4);
    tick(2);
    release_cnt = 0;
    button_press[2] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      release_cnt += int'(release_pulse[2]);
    end
    check("glitch_release_count", 32'(release_cnt),     32'd1);
    check("glitch_release_state", 32'(button_state[2]), 32'h0);

    // Simultaneous press on channels 0 and 3 (channel 1 still held).
    button_press[0] = 1'b1;
    button_press[3] = 1'b1;
    tick(5);
    check("simul_before", 32'(press_pulse), 32'h0);
    tick(1);
    check("simul_press", 32'(press_pulse),  32'h9);
    check("simul_state", 32'(button_state), 32'hB);
    tick(1);
    check("simul_press_gone", 32'(press_pulse), 32'h0);
    button_press[0] = 1'b0;
    tick(6);
    check("simul_release",       32'(release_pulse), 32'h1);
    check("simul_release_press", 32'(press_pulse),   32'h0);
    check("simul_release_state", 32'(button_state),  32'hA);
    button_press[1] = 1'b0;
    tick(10);
    check("pre_reset_state", 32'(button_state), 32'h8);

    // Reset while channel 0 is mid-count (cnt == 2) and channel 3 is held.
    button_press[0] = 1'b1;
    tick(4);
    reset_n = 1'b0;
    #1;
    check("midreset_state",   32'(button_state),  32'h0);
    check("midreset_press",   32'(press_pulse),   32'h0);
    check("midreset_release", 32'(release_pulse), 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    check("postreset_early", 32'(press_pulse), 32'h0);
    tick(1);
    check("postreset_press", 32'(press_pulse),  32'h9);
    check("postreset_state", 32'(button_state), 32'h9);

    // Auto-repeat while channels 0 and 3 are held; press pulse was the last edge.
    for (int j = 1; j <= 40; j++) begin
      tick(1);
`ifdef DEBOUNCE_REPEAT_EN
      rep_exp = (j >= 10) && ((j - 10) % 5 == 0);
      check("repeat_hold", 32'(repeat_pulse[0]), 32'(rep_exp));
      check("repeat_not_press", 32'(press_pulse[0] & repeat_pulse[0]), 32'h0);
`else
      check("repeat_off_hold", 32'(repeat_pulse), 32'h0);
`endif
    end
    button_press[0] = 1'b0;
    release_cnt = 0;
    for (int j = 1; j <= 12; j++) begin
      tick(1);
      release_cnt += int'(release_pulse[0]);
`ifdef DEBOUNCE_REPEAT_EN
      rep_exp = (j == 5);
      check("repeat_release", 32'(repeat_pulse[0]), 32'(rep_exp));
`else
      check("repeat_off_release", 32'(repeat_pulse), 32'h0);
`endif
    end
    check("repeat_release_count", 32'(release_cnt),  32'd1);
    check("final_state",          32'(button_state), 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel button conditioner for the calculator front panel: synchronises each active-high raw button input, filters contact bounce using a per-channel stability counter, and produces a clean held level plus single-cycle press and release pulses. An optional auto-repeat stage issues periodic pulses while a button is held. Sits between the board push-buttons and the calculator control FSM, replacing per-button single-channel debouncers.

## Interface

- CHANNELS, 4: number of independent button channels (≥1).
- STABLE_CYCLES, 4: consecutive cycles a synchronised input must differ from the held level before the level flips (≥1).
- REPEAT_DELAY, 1000: cycles from press pulse to first repeat pulse (≥1; used only with repeat compiled in).
- REPEAT_PERIOD, 250: cycles between subsequent repeat pulses (≥1; used only with repeat compiled in).

- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- button_press  in  CHANNELS  raw active-high buttons, asynchronous to clock.
- button_state  out  CHANNELS  debounced held level per channel.
- press_pulse  out  CHANNELS  one-cycle high on debounced 0→1.
- release_pulse  out  CHANNELS  one-cycle high on debounced 1→0.
- repeat_pulse  out  CHANNELS  one-cycle auto-repeat strobe; constant 0 when repeat is not compiled in.

## Operation

- Per channel: two-flop synchroniser (sync1, sync2 = s), stability counter cnt of width clog2(STABLE_CYCLES+1), held level L.
- Each edge: if s == L, cnt ← 0. If s != L and cnt == STABLE_CYCLES−1: L ← s, cnt ← 0, press_pulse ← s, release_pulse ← ~s. Otherwise cnt ← cnt+1.
- Pulses are registered, high for exactly one cycle, coincident with the first cycle of the new button_state.
- Any return of s to L before the count completes discards progress; bounces shorter than STABLE_CYCLES never reach outputs.
- Channels fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- Reset (asynchronous assert, any time including mid-count): sync regs, L, cnt, repeat counters and all outputs ← 0. A button held through reset release is reported as a fresh press after full latency.

## Timing

- Latency: raw change sampled at edge k → button_state and pulse high after edge k+1+STABLE_CYCLES (STABLE_CYCLES+2 edges).
- Minimum accepted pulse width/gap: STABLE_CYCLES cycles of stable s.
- Repeat (when compiled in): repeat counter rc clears on press pulse; while L == 1, rc increments; repeat_pulse fires when rc reaches REPEAT_DELAY, rc then reloads so next fires REPEAT_PERIOD cycles later, repeating until release. Release pulse clears rc in the same cycle; no repeat_pulse coincides with release_pulse.
- press_pulse and repeat_pulse never both high on one channel in one cycle.

## Configuration

- DEBOUNCE_REPEAT_EN defined: per-channel repeat counters instantiated; repeat_pulse behaves as above.
- Not defined: no repeat counters synthesised; repeat_pulse tied to 0; REPEAT_DELAY/REPEAT_PERIOD ignored.

## Test plan

- Clean press, STABLE_CYCLES=4: button_press[0] 0→1 before edge 0, held → button_state[0] and press_pulse[0] high after edge 5; pulse low after edge 6; level stays 1.
- Bounce: channel 1 toggles every 2 cycles for 20 cycles then held 1 → exactly one press_pulse[1], zero release pulses, after final stable period.
- Glitch: 3-cycle high on channel 2 with STABLE_CYCLES=4 → no pulse, button_state[2] stays 0; then release after held press → single release_pulse[2].
- Simultaneous: channels 0 and 3 pressed same cycle → both press pulses in the same cycle; channel 0 released while 3 held → only release_pulse[0].
- Reset mid-count: assert reset_n=0 at cnt=2 with button held → all outputs 0 immediately; after deassert, press_pulse after full STABLE_CYCLES+2 latency.
- Repeat (DEBOUNCE_REPEAT_EN, DELAY=10, PERIOD=5): hold 40 cycles past press → repeat pulses at press+10, +15, +20, +25, +30, +35, +40; release → release_pulse, no further repeats; without macro repeat_pulse stays 0.
